input_router_vc_lock: RTL and testbench

Parametrised successor to the mesh input router. It decodes the output port for head flits using XY or YX dimension-order routing, selectable by parameter. Each VC holds a lock state machine that keeps the route from head to tail. It also flags protocol and destination errors. Sits between each input buffer and the switch allocator of a router; one instance per input port.

---
 rtl/input_router_vc_lock_if.sv | 61 ++++++
 rtl/input_router_vc_lock.sv | 176 +++++++++++++++++
 tb/tb_input_router_vc_lock.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/input_router_vc_lock_if.sv
// ---------------------------------------------------------------------------
// input_router_vc_lock_if
// Flit bus between an input buffer (master) and the input router (slave).
//
// Handshake: a flit transfers on a cycle where flit_valid_i && flit_ready_i.
// The buffer holds the flit fields stable while flit_valid_i is high and
// flit_ready_i is low. router_port_o is a combinational request that is
// valid in the same cycle as the flit it belongs to.
//
// Signals (names seen from the router):
//   flit_valid_i  flit present at buffer head
//   flit_ready_i  switch accepted the flit this cycle
//   flit_type_i   0 HEAD, 1 BODY, 2 TAIL, 3 HEAD_TAIL
//   vc_id_i       VC of the current flit
//   x_dest_i      destination column (head flits)
//   y_dest_i      destination row (head flits)
//   router_port_o one-hot {local,east,west,south,north}, bit0 = north
//   vc_busy_o     per-VC lock state, 1 = ACTIVE
//   route_err_o   one-cycle error pulse
//   err_vc_o      VC of the most recent error
//   pkt_cnt_o     completed packet count (only with INPUT_ROUTER_PKT_CNT_EN)
// ---------------------------------------------------------------------------
interface input_router_vc_lock_if #(
    parameter int N_COLS = 2,
    parameter int N_ROWS = 2,
    parameter int N_VC   = 3
);
    localparam int VCW = (N_VC   > 1) ? $clog2(N_VC)   : 1;
    localparam int XW  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int YW  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    logic            flit_valid_i;
    logic            flit_ready_i;
    logic [1:0]      flit_type_i;
    logic [VCW-1:0]  vc_id_i;
    logic [XW-1:0]   x_dest_i;
    logic [YW-1:0]   y_dest_i;
    logic [4:0]      router_port_o;
    logic [N_VC-1:0] vc_busy_o;
    logic            route_err_o;
    logic [VCW-1:0]  err_vc_o;
`ifdef INPUT_ROUTER_PKT_CNT_EN
    logic [15:0]     pkt_cnt_o;
`endif

    modport master (
        output flit_valid_i, flit_ready_i, flit_type_i, vc_id_i, x_dest_i, y_dest_i,
        input  router_port_o, vc_busy_o, route_err_o, err_vc_o
`ifdef INPUT_ROUTER_PKT_CNT_EN
        , input pkt_cnt_o
`endif
    );

    modport slave (
        input  flit_valid_i, flit_ready_i, flit_type_i, vc_id_i, x_dest_i, y_dest_i,
        output router_port_o, vc_busy_o, route_err_o, err_vc_o
`ifdef INPUT_ROUTER_PKT_CNT_EN
        , output pkt_cnt_o
`endif
    );
endinterface

// File: rtl/input_router_vc_lock.sv
// ---------------------------------------------------------------------------
// input_router_vc_lock
// Per-input-port router stage of a 2D mesh. Head flits get an output port by
// dimension-order routing (XY or YX); each VC keeps an IDLE/ACTIVE lock that
// pins the head's route until the tail. Protocol and destination errors are
// flagged with a one-cycle pulse plus the offending VC.
//
// Ports:
//   clk   clock
//   arst  synchronous active-high reset
//   bus   input_router_vc_lock_if.slave (flit handshake, route request,
//         VC lock state, error reporting)
//
// Optional feature: define INPUT_ROUTER_PKT_CNT_EN to add a saturating
// 16-bit count (bus.pkt_cnt_o) of packets completed without error.
// ---------------------------------------------------------------------------
module input_router_vc_lock #(
    parameter int ROUTER_X_ID  = 0,
    parameter int ROUTER_Y_ID  = 0,
    parameter int N_COLS       = 2,
    parameter int N_ROWS       = 2,
    parameter int N_VC         = 3,
    parameter int ROUTING_MODE = 0
) (
    input logic                  clk,
    input logic                  arst,
    input_router_vc_lock_if.slave bus
);
    localparam int VCW = (N_VC   > 1) ? $clog2(N_VC)   : 1;
    localparam int XW  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int YW  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    // One extra bit so N_COLS / N_ROWS / N_VC stay representable when they
    // are exact powers of two.
    localparam logic [XW:0]   COLS_L = N_COLS[XW:0];
    localparam logic [YW:0]   ROWS_L = N_ROWS[YW:0];
    localparam logic [VCW:0]  NVC_L  = N_VC[VCW:0];
    localparam logic [XW-1:0] X_ID_L = ROUTER_X_ID[XW-1:0];
    localparam logic [YW-1:0] Y_ID_L = ROUTER_Y_ID[YW-1:0];

    localparam logic [4:0] P_NORTH = 5'b00001;
    localparam logic [4:0] P_SOUTH = 5'b00010;
    localparam logic [4:0] P_WEST  = 5'b00100;
    localparam logic [4:0] P_EAST  = 5'b01000;
    localparam logic [4:0] P_LOCAL = 5'b10000;

    typedef enum logic [1:0] {
        FT_HEAD      = 2'd0,
        FT_BODY      = 2'd1,
        FT_TAIL      = 2'd2,
        FT_HEAD_TAIL = 2'd3
    } flit_type_t;

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_ACTIVE = 1'b1
    } vc_state_t;

    vc_state_t      r_vc_state [N_VC];
    logic [4:0]     r_route    [N_VC];
    logic           r_route_err;
    logic [VCW-1:0] r_err_vc;

    function automatic logic [4:0] calc_route(input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic x_eq;
        logic y_eq;
        logic [4:0] x_dir;
        logic [4:0] y_dir;
        x_eq  = (x == X_ID_L);
        y_eq  = (y == Y_ID_L);
        x_dir = (x < X_ID_L) ? P_WEST  : P_EAST;
        y_dir = (y < Y_ID_L) ? P_SOUTH : P_NORTH;
        if (x_eq && y_eq)
            return P_LOCAL;
        else if (ROUTING_MODE == 0)
            return x_eq ? y_dir : x_dir;
        else
            return y_eq ? x_dir : y_dir;
    endfunction

    flit_type_t     w_type;
    logic           w_vc_ok;
    logic [VCW-1:0] w_vc;
    logic           w_is_head;
    logic           w_dest_ok;
    logic           w_active;
    logic [4:0]     w_route;
    logic [4:0]     w_port;
    logic           w_err;
    logic           w_fire;
    logic           w_apply;
    logic           w_pkt_done;

    assign w_type    = flit_type_t'(bus.flit_type_i);
    // A vc_id beyond N_VC (non power-of-two N_VC) is ignored: no request,
    // no state change, no error. Indexing is clamped to VC0 in that case.
    assign w_vc_ok   = ({1'b0, bus.vc_id_i} < NVC_L);
    assign w_vc      = w_vc_ok ? bus.vc_id_i : '0;
    assign w_is_head = (w_type == FT_HEAD) || (w_type == FT_HEAD_TAIL);
    assign w_dest_ok = ({1'b0, bus.x_dest_i} < COLS_L) && ({1'b0, bus.y_dest_i} < ROWS_L);
    assign w_active  = (r_vc_state[w_vc] == VC_ACTIVE);
    assign w_route   = calc_route(bus.x_dest_i, bus.y_dest_i);

    always_comb begin
        w_port = 5'b00000;
        if (bus.flit_valid_i && w_vc_ok) begin
            if (w_is_head && w_dest_ok)
                w_port = w_route;
            else if (!w_is_head && w_active)
                w_port = r_route[w_vc];
        end
    end

    // Errors are raised on presentation, independent of ready, so a stalled
    // bad flit pulses every cycle it is held.
    assign w_err = bus.flit_valid_i && w_vc_ok &&
                   (w_is_head ? (!w_dest_ok || w_active) : !w_active);

    assign w_fire = bus.flit_valid_i && bus.flit_ready_i && w_vc_ok;
    // Handshakes that actually move the lock: legal heads (including a
    // preempting head) and body/tail on an active VC.
    assign w_apply = w_fire && (w_is_head ? w_dest_ok : w_active);
    assign w_pkt_done = w_fire && !w_err &&
                        ((w_type == FT_TAIL) || (w_type == FT_HEAD_TAIL));

`ifdef INPUT_ROUTER_PKT_CNT_EN
    logic [15:0] r_pkt_cnt;
    always_ff @(posedge clk) begin
        if (arst)
            r_pkt_cnt <= 16'h0000;
        else if (w_pkt_done && (r_pkt_cnt != 16'hFFFF))
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
    assign bus.pkt_cnt_o = r_pkt_cnt;
`else
    logic w_pkt_done_unused;
    assign w_pkt_done_unused = w_pkt_done;
`endif

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int i = 0; i < N_VC; i++) begin
                r_vc_state[i] <= VC_IDLE;
                r_route[i]    <= 5'b00000;
            end
            r_route_err <= 1'b0;
            r_err_vc    <= '0;
        end else begin
            r_route_err <= w_err;
            if (w_err)
                r_err_vc <= w_vc;
            if (w_apply) begin
                case (w_type)
                    FT_HEAD: begin
                        r_vc_state[w_vc] <= VC_ACTIVE;
                        r_route[w_vc]    <= w_route;
                    end
                    FT_HEAD_TAIL: r_vc_state[w_vc] <= VC_IDLE;
                    FT_BODY:      r_vc_state[w_vc] <= VC_ACTIVE;
                    FT_TAIL:      r_vc_state[w_vc] <= VC_IDLE;
                    default:      r_vc_state[w_vc] <= r_vc_state[w_vc];
                endcase
            end
        end
    end

    always_comb begin
        bus.vc_busy_o = '0;
        for (int i = 0; i < N_VC; i++)
            bus.vc_busy_o[i] = (r_vc_state[i] == VC_ACTIVE);
    end

    assign bus.router_port_o = w_port;
    assign bus.route_err_o   = r_route_err;
    assign bus.err_vc_o      = r_err_vc;
endmodule

// File: tb/tb_input_router_vc_lock.sv
module tb_input_router_vc_lock;
    localparam logic [1:0] HD = 2'd0, BD = 2'd1, TL = 2'd2, HT = 2'd3;
    localparam logic [4:0] PN = 5'b00001, PS = 5'b00010, PW = 5'b00100,
                           PE = 5'b01000, PL = 5'b10000;

    logic clk;
    logic arst;
    logic v, r;
    logic [1:0] t, vc, x, y;

    input_router_vc_lock_if #(.N_COLS(3), .N_ROWS(3), .N_VC(3)) bus_xy ();
    input_router_vc_lock_if #(.N_COLS(3), .N_ROWS(3), .N_VC(3)) bus_yx ();

    assign bus_xy.flit_valid_i = v;
    assign bus_xy.flit_ready_i = r;
    assign bus_xy.flit_type_i  = t;
    assign bus_xy.vc_id_i      = vc;
    assign bus_xy.x_dest_i     = x;
    assign bus_xy.y_dest_i     = y;
    assign bus_yx.flit_valid_i = v;
    assign bus_yx.flit_ready_i = r;
    assign bus_yx.flit_type_i  = t;
    assign bus_yx.vc_id_i      = vc;
    assign bus_yx.x_dest_i     = x;
    assign bus_yx.y_dest_i     = y;

    input_router_vc_lock #(.ROUTER_X_ID(1), .ROUTER_Y_ID(1), .N_COLS(3), .N_ROWS(3),
                           .N_VC(3), .ROUTING_MODE(0)) dut_xy (
        .clk(clk), .arst(arst), .bus(bus_xy.slave));
    input_router_vc_lock #(.ROUTER_X_ID(1), .ROUTER_Y_ID(1), .N_COLS(3), .N_ROWS(3),
                           .N_VC(3), .ROUTING_MODE(1)) dut_yx (
        .clk(clk), .arst(arst), .bus(bus_yx.slave));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    typedef struct packed {
        logic [15:0] id;
        logic [4:0]  port;
        logic [4:0]  yx;
        logic [2:0]  busy;
        logic        err;
        logic [1:0]  evc;
        logic        cnt_chk;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    task automatic check(input string name, input int id, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    // driver: inputs change 2 time units after the rising edge; the monitor
    // samples at the falling edge of the same cycle.
    task automatic drive(input logic rst_in, input logic v_in, input logic r_in,
                         input logic [1:0] t_in, input logic [1:0] vc_in,
                         input logic [1:0] x_in, input logic [1:0] y_in,
                         input logic [4:0] e_port, input logic [4:0] e_yx,
                         input logic [2:0] e_busy, input logic e_err,
                         input logic [1:0] e_evc, input int e_cnt);
        exp_t e;
        @(posedge clk);
        #2;
        arst = rst_in; v = v_in; r = r_in; t = t_in; vc = vc_in; x = x_in; y = y_in;
        vec_id++;
        e.id      = vec_id[15:0];
        e.port    = e_port;
        e.yx      = e_yx;
        e.busy    = e_busy;
        e.err     = e_err;
        e.evc     = e_evc;
        e.cnt_chk = (e_cnt >= 0);
        e.cnt     = e_cnt[15:0];
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [2:0] e_busy, input logic e_err,
                        input logic [1:0] e_evc, input int e_cnt);
        drive(1'b0, 1'b0, 1'b0, BD, 2'd0, 2'd0, 2'd0, 5'b0, 5'b0, e_busy, e_err, e_evc, e_cnt);
    endtask

    // monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("router_port_xy", int'(e.id), {11'b0, bus_xy.router_port_o}, {11'b0, e.port});
            check("router_port_yx", int'(e.id), {11'b0, bus_yx.router_port_o}, {11'b0, e.yx});
            check("vc_busy",        int'(e.id), {13'b0, bus_xy.vc_busy_o},     {13'b0, e.busy});
            check("route_err",      int'(e.id), {15'b0, bus_xy.route_err_o},   {15'b0, e.err});
            check("err_vc",         int'(e.id), {14'b0, bus_xy.err_vc_o},      {14'b0, e.evc});
`ifdef INPUT_ROUTER_PKT_CNT_EN
            if (e.cnt_chk)
                check("pkt_cnt", int'(e.id), bus_xy.pkt_cnt_o, e.cnt);
`endif
        end
    end

    initial begin
        arst = 1'b1; v = 1'b0; r = 1'b0; t = HD; vc = 2'd0; x = 2'd0; y = 2'd0;
        // reset state
        drive(1, 0, 0, HD, 0, 0, 0, 5'b0, 5'b0, 3'b000, 0, 0, 0);
        // VC0 packet to (2,0): XY east, YX south
        drive(0, 1, 1, HD, 0, 2, 0, PE, PS, 3'b000, 0, 0, -1);
        drive(0, 1, 1, BD, 0, 0, 0, PE, PS, 3'b001, 0, 0, -1);
        drive(0, 1, 1, TL, 0, 0, 0, PE, PS, 3'b001, 0, 0, -1);
        idle(3'b000, 0, 0, 1);
        // single-flit packet to self
        drive(0, 1, 1, HT, 0, 1, 1, PL, PL, 3'b000, 0, 0, -1);
        idle(3'b000, 0, 0, 2);
        // interleaved VC0 (0,1) and VC2 (1,2)
        drive(0, 1, 1, HD, 0, 0, 1, PW, PW, 3'b000, 0, 0, -1);
        drive(0, 1, 1, HD, 2, 1, 2, PN, PN, 3'b001, 0, 0, -1);
        drive(0, 1, 1, BD, 0, 0, 0, PW, PW, 3'b101, 0, 0, -1);
        drive(0, 1, 1, BD, 2, 0, 0, PN, PN, 3'b101, 0, 0, -1);
        drive(0, 1, 1, TL, 0, 0, 0, PW, PW, 3'b101, 0, 0, -1);
        drive(0, 1, 1, BD, 2, 0, 0, PN, PN, 3'b100, 0, 0, -1);
        drive(0, 1, 1, TL, 2, 0, 0, PN, PN, 3'b100, 0, 0, 3);
        idle(3'b000, 0, 0, 4);
        // stalled head on VC1 to (2,2)
        for (int i = 0; i < 4; i++)
            drive(0, 1, 0, HD, 1, 2, 2, PE, PN, 3'b000, 0, 0, -1);
        drive(0, 1, 1, HD, 1, 2, 2, PE, PN, 3'b000, 0, 0, -1);
        idle(3'b010, 0, 0, -1);
        drive(0, 1, 1, TL, 1, 0, 0, PE, PN, 3'b010, 0, 0, -1);
        idle(3'b000, 0, 0, 5);
        // BODY on idle VC1
        drive(0, 1, 1, BD, 1, 0, 0, 5'b0, 5'b0, 3'b000, 0, 0, -1);
        idle(3'b000, 1, 1, -1);
        idle(3'b000, 0, 1, -1);
        // out-of-range x on VC2
        drive(0, 1, 1, HD, 2, 3, 0, 5'b0, 5'b0, 3'b000, 0, 1, -1);
        idle(3'b000, 1, 2, -1);
        idle(3'b000, 0, 2, -1);
        // erroring BODY held without ready: pulses while presented
        drive(0, 1, 0, BD, 0, 0, 0, 5'b0, 5'b0, 3'b000, 0, 2, -1);
        drive(0, 1, 0, BD, 0, 0, 0, 5'b0, 5'b0, 3'b000, 1, 0, -1);
        idle(3'b000, 1, 0, -1);
        idle(3'b000, 0, 0, -1);
        // preempting head on active VC0 overwrites the route
        drive(0, 1, 1, HD, 0, 2, 0, PE, PS, 3'b000, 0, 0, -1);
        drive(0, 1, 1, HD, 0, 0, 1, PW, PW, 3'b001, 0, 0, -1);
        drive(0, 1, 1, BD, 0, 0, 0, PW, PW, 3'b001, 1, 0, -1);
        drive(0, 1, 1, TL, 0, 0, 0, PW, PW, 3'b001, 0, 0, -1);
        idle(3'b000, 0, 0, 6);
        // reset mid-packet, then BODY errors
        drive(0, 1, 1, HD, 1, 0, 0, PW, PS, 3'b000, 0, 0, -1);
        drive(1, 0, 0, BD, 0, 0, 0, 5'b0, 5'b0, 3'b010, 0, 0, 6);
        drive(0, 1, 1, BD, 1, 0, 0, 5'b0, 5'b0, 3'b000, 0, 0, 0);
        idle(3'b000, 1, 1, 0);
        // three good packets and an erroring TAIL
        drive(0, 1, 1, HT, 0, 0, 2, PW, PN, 3'b000, 0, 1, -1);
        drive(0, 1, 1, HT, 1, 1, 1, PL, PL, 3'b000, 0, 1, -1);
        drive(0, 1, 1, HT, 2, 2, 1, PE, PE, 3'b000, 0, 1, -1);
        drive(0, 1, 1, TL, 0, 0, 0, 5'b0, 5'b0, 3'b000, 0, 1, 3);
        idle(3'b000, 1, 0, 3);
`ifdef INPUT_ROUTER_PKT_CNT_EN
        // saturation
        force dut_xy.r_pkt_cnt = 16'hFFFF;
        @(posedge clk);
        #1 release dut_xy.r_pkt_cnt;
        drive(0, 1, 1, HT, 0, 1, 1, PL, PL, 3'b000, 0, 0, 65535);
        idle(3'b000, 0, 0, 65535);
`endif
        begin
            int budget;
            budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
